// File: rtl/gpio_input_event_capture.sv
// GPIO pad input capture: two-flop synchroniser, per-pad debounce, edge detection,
// and a show-ahead event FIFO drained by the core over valid/ready.
module gpio_input_event_capture #(
  parameter int NUM_PADS   = 44,
  parameter int PAD_IDX_W  = 6,
  parameter int DEBOUNCE_W = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PADS-1:0]   gpio_in,
  input  logic [NUM_PADS-1:0]   pad_enable,
  input  logic [NUM_PADS-1:0]   rise_en,
  input  logic [NUM_PADS-1:0]   fall_en,
  input  logic [DEBOUNCE_W-1:0] debounce_limit,
  output logic [NUM_PADS-1:0]   in_state,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [PAD_IDX_W-1:0]  evt_pad,
  output logic                  evt_level,
  output logic [TS_W-1:0]       evt_timestamp,
  output logic                  overflow,
  input  logic                  overflow_clear
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REC_W = PAD_IDX_W + 1 + TS_W;

  logic [NUM_PADS-1:0]   r_sync1, r_sync2, r_in_state, r_pending, r_pend_level;
  logic [DEBOUNCE_W-1:0] r_cnt [NUM_PADS];
  logic [TS_W-1:0]       r_ts;
  logic [REC_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W:0]        r_wr_ptr, r_rd_ptr;
  logic                  r_overflow;

  logic [NUM_PADS-1:0]   w_diff, w_update, w_edge, w_lost, w_cand, w_push_sel;
  logic [PAD_IDX_W-1:0]  w_push_idx;
  logic                  w_push_level, w_push, w_pop, w_full, w_empty;

  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    assign w_diff[gi]   = r_sync2[gi] ^ r_in_state[gi];
    // >= rather than == keeps the counter bounded if the limit is lowered mid-count
    assign w_update[gi] = w_diff[gi] && (r_cnt[gi] >= debounce_limit);
    assign w_edge[gi]   = w_update[gi] && pad_enable[gi] &&
                          (r_sync2[gi] ? rise_en[gi] : fall_en[gi]);
    assign w_lost[gi]   = w_edge[gi] && r_pending[gi] && !w_push_sel[gi];
    assign w_cand[gi]   = r_pending[gi] && pad_enable[gi];
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && evt_ready;

  // Lowest-index pending pad wins; a pop in the same cycle frees a slot when full
  always_comb begin
    w_push_idx   = '0;
    w_push_level = 1'b0;
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_push_idx   = PAD_IDX_W'(i);
        w_push_level = r_pend_level[i];
      end
    end
    w_push     = (|w_cand) && (!w_full || w_pop);
    w_push_sel = w_push ? (NUM_PADS'(1) << w_push_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_in_state   <= '0;
      r_pending    <= '0;
      r_pend_level <= '0;
      for (int i = 0; i < NUM_PADS; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NUM_PADS; i++) begin
        if (!w_diff[i] || w_update[i]) r_cnt[i] <= '0;
        else                            r_cnt[i] <= r_cnt[i] + 1'b1;
        if (w_update[i]) r_in_state[i] <= r_sync2[i];
        // A new edge re-arms the pad even when it is being pushed this cycle
        if (!pad_enable[i]) begin
          r_pending[i] <= 1'b0;
        end else if (w_edge[i]) begin
          r_pending[i]    <= 1'b1;
          r_pend_level[i] <= r_sync2[i];
        end else if (w_push_sel[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts       <= '0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (|w_lost)             r_overflow <= 1'b1;
      else if (overflow_clear) r_overflow <= 1'b0;
      if (w_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= {w_push_idx, w_push_level, r_ts};
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign in_state  = r_in_state;
  assign evt_valid = !w_empty;
  assign overflow  = r_overflow;
  assign {evt_pad, evt_level, evt_timestamp} = r_mem[r_rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_gpio_input_event_capture.sv
// Directed bench for gpio_input_event_capture: expected events are queued when edges
// are driven and compared as the core pops them.
module tb_gpio_input_event_capture;
  logic        clk = 1'b0;
  logic        reset;
  logic [43:0] gpio_in, pad_enable, rise_en, fall_en, in_state;
  logic [7:0]  debounce_limit;
  logic        evt_valid, evt_ready, evt_level, overflow, overflow_clear;
  logic [5:0]  evt_pad;
  logic [15:0] evt_timestamp;

  typedef struct {
    int pad;
    bit level;
    int ts;
    bit chk_ts;
  } evt_t;

  evt_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;
  int   rst_cyc = 0;

  gpio_input_event_capture dut (
    .clk(clk), .reset(reset), .gpio_in(gpio_in), .pad_enable(pad_enable),
    .rise_en(rise_en), .fall_en(fall_en), .debounce_limit(debounce_limit),
    .in_state(in_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_pad(evt_pad), .evt_level(evt_level), .evt_timestamp(evt_timestamp),
    .overflow(overflow), .overflow_clear(overflow_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Timestamp the DUT holds just before clock edge number k
  function automatic int ts_at(input int k);
    return (k - rst_cyc - 1) & 16'hFFFF;
  endfunction

  task automatic expect_evt(input int pad, input bit level, input int ts, input bit chk_ts);
    evt_t e;
    e.pad = pad; e.level = level; e.ts = ts; e.chk_ts = chk_ts;
    sb.push_back(e);
  endtask

  // One clock: sample handshake on the falling edge, return 1 time unit after the rising edge
  task automatic cyc();
    evt_t e;
    @(negedge clk);
    if (evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_evt_valid", {63'd0, evt_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("evt_pad", {58'd0, evt_pad}, 64'(e.pad));
        chk("evt_level", {63'd0, evt_level}, {63'd0, e.level});
        if (e.chk_ts) chk("evt_timestamp", {48'd0, evt_timestamp}, 64'(e.ts));
        $display("event pad=%0d level=%0d ts=%0d (queue left %0d)",
                 evt_pad, evt_level, evt_timestamp, sb.size());
      end
    end
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wait_drain(input int n);
    int k = 0;
    while (sb.size() > 0 && k < n) begin
      cyc();
      k++;
    end
    chk("drain_timeout_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    gpio_in = '0;
    pad_enable = '1;
    rise_en = '1;
    fall_en = '1;
    debounce_limit = 8'd0;
    evt_ready = 1'b0;
    overflow_clear = 1'b0;
    cycles(3);
    reset = 1'b0;
    rst_cyc = cyc_n;

    // Reset state
    chk("rst_evt_valid", {63'd0, evt_valid}, 64'd0);
    chk("rst_evt_pad", {58'd0, evt_pad}, 64'd0);
    chk("rst_evt_level", {63'd0, evt_level}, 64'd0);
    chk("rst_evt_ts", {48'd0, evt_timestamp}, 64'd0);
    chk("rst_in_state", {20'd0, in_state}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);

    // Pad 5 rise, limit 0: valid exactly 4 cycles later
    c = cyc_n;
    gpio_in[5] = 1'b1;
    expect_evt(5, 1'b1, ts_at(c + 4), 1'b1);
    cycles(3);
    chk("lat_valid_early", {63'd0, evt_valid}, 64'd0);
    cyc();
    chk("lat_valid_on_time", {63'd0, evt_valid}, 64'd1);
    chk("in_state5", {63'd0, in_state[5]}, 64'd1);
    evt_ready = 1'b1;
    wait_drain(10);

    // limit 4: 3-cycle glitch rejected, 10-cycle pulse gives rise then fall
    debounce_limit = 8'd4;
    gpio_in[0] = 1'b1;
    cycles(3);
    gpio_in[0] = 1'b0;
    cycles(15);
    chk("glitch_in_state0", {63'd0, in_state[0]}, 64'd0);
    chk("glitch_no_evt", {63'd0, evt_valid}, 64'd0);
    expect_evt(0, 1'b1, 0, 1'b0);
    expect_evt(0, 1'b0, 0, 1'b0);
    gpio_in[0] = 1'b1;
    cycles(10);
    chk("pulse_in_state0", {63'd0, in_state[0]}, 64'd1);
    gpio_in[0] = 1'b0;
    wait_drain(40);
    debounce_limit = 8'd0;

    // Simultaneous rises on 3, 17, 43: index order, consecutive timestamps
    c = cyc_n;
    gpio_in[3] = 1'b1; gpio_in[17] = 1'b1; gpio_in[43] = 1'b1;
    expect_evt(3, 1'b1, ts_at(c + 4), 1'b1);
    expect_evt(17, 1'b1, ts_at(c + 5), 1'b1);
    expect_evt(43, 1'b1, ts_at(c + 6), 1'b1);
    wait_drain(20);

    // 12 rises with consumer stalled: 8 queued, 4 held pending
    evt_ready = 1'b0;
    for (int p = 20; p < 32; p++) begin
      gpio_in[p] = 1'b1;
      expect_evt(p, 1'b1, 0, 1'b0);
    end
    cycles(20);
    chk("stall_valid", {63'd0, evt_valid}, 64'd1);
    chk("stall_overflow", {63'd0, overflow}, 64'd0);
    chk("stall_head_pad", {58'd0, evt_pad}, 64'd20);
    cycles(2);
    chk("stall_head_stable", {58'd0, evt_pad}, 64'd20);
    chk("stall_head_level", {63'd0, evt_level}, 64'd1);
    evt_ready = 1'b1;
    wait_drain(40);

    // Two edges on pad 9 while FIFO full: overflow, latest level survives
    evt_ready = 1'b0;
    for (int p = 32; p < 40; p++) begin
      gpio_in[p] = 1'b1;
      expect_evt(p, 1'b1, 0, 1'b0);
    end
    cycles(14);
    chk("full_overflow_pre", {63'd0, overflow}, 64'd0);
    gpio_in[9] = 1'b1;
    cycles(6);
    gpio_in[9] = 1'b0;
    cycles(6);
    chk("full_overflow_set", {63'd0, overflow}, 64'd1);
    expect_evt(9, 1'b0, 0, 1'b0);
    overflow_clear = 1'b1;
    cyc();
    overflow_clear = 1'b0;
    chk("overflow_cleared", {63'd0, overflow}, 64'd0);
    evt_ready = 1'b1;
    wait_drain(40);

    // Pad 2 with only falling edges enabled, then with the pad disabled
    rise_en[2] = 1'b0;
    gpio_in[2] = 1'b1; cycles(6);
    expect_evt(2, 1'b0, 0, 1'b0);
    gpio_in[2] = 1'b0; cycles(6);
    gpio_in[2] = 1'b1; cycles(6);
    expect_evt(2, 1'b0, 0, 1'b0);
    gpio_in[2] = 1'b0;
    wait_drain(20);
    pad_enable[2] = 1'b0;
    gpio_in[2] = 1'b1; cycles(6);
    chk("dis_in_state_hi", {63'd0, in_state[2]}, 64'd1);
    chk("dis_no_evt_rise", {63'd0, evt_valid}, 64'd0);
    gpio_in[2] = 1'b0; cycles(6);
    chk("dis_in_state_lo", {63'd0, in_state[2]}, 64'd0);
    chk("dis_no_evt_fall", {63'd0, evt_valid}, 64'd0);
    pad_enable[2] = 1'b1;
    rise_en[2] = 1'b1;

    // Reset with 3 queued events discards them; a pad held high re-reports after reset
    evt_ready = 1'b0;
    gpio_in[40] = 1'b1; gpio_in[41] = 1'b1; gpio_in[42] = 1'b1;
    cycles(10);
    chk("pre_reset_valid", {63'd0, evt_valid}, 64'd1);
    reset = 1'b1;
    cyc();
    chk("reset_valid_cleared", {63'd0, evt_valid}, 64'd0);
    chk("reset_in_state", {20'd0, in_state}, 64'd0);
    sb.delete();
    gpio_in = '0;
    gpio_in[40] = 1'b1;
    cycles(3);
    reset = 1'b0;
    rst_cyc = cyc_n;
    c = cyc_n;
    expect_evt(40, 1'b1, ts_at(c + 4), 1'b1);
    evt_ready = 1'b1;
    wait_drain(20);
    cycles(3);
    chk("final_valid", {63'd0, evt_valid}, 64'd0);
    chk("final_overflow", {63'd0, overflow}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_input_event_capture.md
Name: gpio_input_event_capture

Overview:
- Receive-side companion to the user project GPIO outputs: samples the 44 `gpio_in` pad inputs, synchronises and debounces them, and detects rising/falling edges.
- Queues one event record per edge into a FIFO, drained by the user project core over a valid/ready handshake.
- Sits inside the openframe user project, directly on the pad input bus, clocked from the user core clock.

Parameters:
- NUM_PADS, 44, number of GPIO pad inputs handled (fixed pad count of the openframe).
- PAD_IDX_W, 6, width of the pad index field (ceil(log2(NUM_PADS))).
- DEBOUNCE_W, 8, width of per-pad debounce counter and limit.
- FIFO_DEPTH, 8, event FIFO entries (power of two).
- TS_W, 16, timestamp counter width.

Ports:
- clk  input  1  core clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- gpio_in  input  NUM_PADS  raw pad input levels (asynchronous to clk).
- pad_enable  input  NUM_PADS  per-pad event enable.
- rise_en  input  NUM_PADS  per-pad rising-edge event enable.
- fall_en  input  NUM_PADS  per-pad falling-edge event enable.
- debounce_limit  input  DEBOUNCE_W  common debounce length in cycles.
- in_state  output  NUM_PADS  debounced pad levels.
- evt_valid  output  1  FIFO head is valid.
- evt_ready  input  1  consumer accepts head.
- evt_pad  output  PAD_IDX_W  pad index of head event.
- evt_level  output  1  new level of the pad (1 = rise, 0 = fall).
- evt_timestamp  output  TS_W  timestamp counter value when the event was pushed.
- overflow  output  1  sticky: an edge was lost.
- overflow_clear  input  1  clears `overflow`.

Behaviour:
- **Reset.** Sync flops, `in_state`, debounce counters, pending bits, FIFO pointers, timestamp and `overflow` all clear to 0. Outputs at reset: `evt_valid`=0, `evt_pad`=0, `evt_level`=0, `evt_timestamp`=0, `in_state`=0. Reset mid-operation discards all queued and pending events.
- **Synchronisation.** Two-flop synchroniser per pad, giving `sync`.
- **Debounce (per pad).** Each cycle where `sync`≠`in_state`:
  - if cnt==`debounce_limit`: `in_state`<=`sync`, cnt<=0;
  - else cnt<=cnt+1.
  - Any cycle where `sync`==`in_state`: cnt<=0, so glitches shorter than limit+1 cycles are rejected.
  - limit=0: `in_state` follows `sync` one cycle later. Counter never wraps; it saturates at the limit by construction.
- **Edge detect.** On the cycle `in_state` updates:
  - a rise (0→1) with `pad_enable`&`rise_en`, or a fall with `pad_enable`&`fall_en`, sets pending[i]<=1 and pend_level[i]<=new level;
  - an edge on a pad already pending sets `overflow`, overwrites pend_level, and keeps pending.
  - `pad_enable`[i]=0 clears pending[i] (enable wins over a simultaneous set). `in_state` still tracks.
  - A pad held high through reset produces a rising event once enabled and the debounce completes.
- **Arbiter.**
  - Each cycle, if FIFO not full, the lowest-index pending pad is pushed as {pad, pend_level, timestamp} and its pending bit clears.
  - A simultaneous new edge on the pushed pad re-sets pending; this is not an overflow.
  - At most one push per cycle. FIFO full: pending bits hold, no loss, no overflow.
- **FIFO.**
  - Show-ahead; push data visible on `evt_*` the cycle after the push edge.
  - Pop on `evt_valid`&`evt_ready`. Simultaneous push and pop when full is permitted. `evt_ready` while empty is ignored.
  - `evt_*` fields hold stable while `evt_valid`&!`evt_ready`.
- **Timestamp.** Free-running TS_W counter, wraps 0xFFFF→0.
- **Overflow.** `overflow_clear` clears `overflow`; a loss in the same cycle as the clear takes priority (stays 1).
- **Latency.** `gpio_in` stable before edge E0 → `in_state` at E2+L (L=`debounce_limit`) → push at E3+L → `evt_valid`=1 after E3+L, when no contention and FIFO not full.

Test Plan:
- Reset, then pad 5 low→high with limit=0 and all enables set → `evt_valid` rises exactly 4 cycles later with `evt_pad`=5, `evt_level`=1, `evt_timestamp` = counter at push; `in_state`[5]=1.
- limit=4: 3-cycle pulse on pad 0 → no event, `in_state`[0] stays 0; 10-cycle pulse → rise event, then fall event, both pad 0.
- Pads 3, 17 and 43 rise in the same cycle → three events in order 3, 17, 43 on consecutive cycles, timestamps differing by 1.
- `evt_ready`=0 and 12 single edges on distinct pads → 8 queued, 4 pending, `overflow`=0; drain with `evt_ready`=1 → all 12 delivered in index order.
- Two edges on pad 9 while the FIFO is full → `overflow`=1, one event for pad 9 with the latest level; `overflow_clear` → `overflow`=0.
- `rise_en`[2]=0, `fall_en`[2]=1, toggle pad 2 → only falling events; `pad_enable`[2]=0 → no events, `in_state` still follows; reset asserted with 3 events queued → `evt_valid`=0 the next cycle.
